// File: rtl/rvb_shifter_issue.sv
// Issue-side adapter for the bitmanip shifter: buffers one request, gates issue on
// tag credit, tracks in-flight tags in a FIFO and pairs results with tags for writeback.
module rvb_shifter_issue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAGW  = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_insn,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [XLEN-1:0] req_rs3,
    input  logic [TAGW-1:0] req_tag,
    output logic            unit_din_valid,
    input  logic            unit_din_ready,
    output logic [XLEN-1:0] unit_din_rs1,
    output logic [XLEN-1:0] unit_din_rs2,
    output logic [XLEN-1:0] unit_din_rs3,
    output logic            unit_din_insn3,
    output logic            unit_din_insn13,
    output logic            unit_din_insn14,
    output logic            unit_din_insn26,
    output logic            unit_din_insn27,
    output logic            unit_din_insn29,
    output logic            unit_din_insn30,
    input  logic            unit_dout_valid,
    output logic            unit_dout_ready,
    input  logic [XLEN-1:0] unit_dout_rd,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] wb_rd,
    output logic [TAGW-1:0] wb_tag,
    output logic            busy,
    output logic            err
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DEPTH);

    logic            iss_valid_q, iss_valid_d;
    logic [XLEN-1:0] iss_rs1_q, iss_rs1_d;
    logic [XLEN-1:0] iss_rs2_q, iss_rs2_d;
    logic [XLEN-1:0] iss_rs3_q, iss_rs3_d;
    logic [TAGW-1:0] iss_tag_q, iss_tag_d;
    // Decode bits packed as {insn30, insn29, insn27, insn26, insn14, insn13, insn3}
    logic [6:0]      iss_bits_q, iss_bits_d;

    logic [TAGW-1:0] tag_mem_q [DEPTH];
    logic [TAGW-1:0] tag_mem_d [DEPTH];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic            wb_valid_q, wb_valid_d;
    logic [XLEN-1:0] wb_rd_q, wb_rd_d;
    logic [TAGW-1:0] wb_tag_q, wb_tag_d;
    logic            err_q, err_d;

    logic req_fire, iss_fire, res_fire, pop;

    // Credit uses the registered count only; a same-cycle pop frees a slot next cycle.
    assign unit_din_valid  = iss_valid_q && (cnt_q < CNT_MAX);
    assign iss_fire        = unit_din_valid && unit_din_ready;
    assign req_ready       = !iss_valid_q || iss_fire;
    assign req_fire        = req_valid && req_ready;
    assign unit_dout_ready = !wb_valid_q || wb_ready;
    assign res_fire        = unit_dout_valid && unit_dout_ready;
    assign pop             = res_fire && (cnt_q != '0);

    assign unit_din_rs1    = iss_rs1_q;
    assign unit_din_rs2    = iss_rs2_q;
    assign unit_din_rs3    = iss_rs3_q;
    assign unit_din_insn30 = iss_bits_q[6];
    assign unit_din_insn29 = iss_bits_q[5];
    assign unit_din_insn27 = iss_bits_q[4];
    assign unit_din_insn26 = iss_bits_q[3];
    assign unit_din_insn14 = iss_bits_q[2];
    assign unit_din_insn13 = iss_bits_q[1];
    assign unit_din_insn3  = iss_bits_q[0];

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_tag   = wb_tag_q;
    assign err      = err_q;
    assign busy     = (cnt_q != '0) || wb_valid_q || iss_valid_q;

    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_rs1_d   = iss_rs1_q;
        iss_rs2_d   = iss_rs2_q;
        iss_rs3_d   = iss_rs3_q;
        iss_tag_d   = iss_tag_q;
        iss_bits_d  = iss_bits_q;
        if (req_fire) begin
            iss_valid_d = 1'b1;
            iss_rs1_d   = req_rs1;
            iss_rs2_d   = req_rs2;
            iss_rs3_d   = req_rs3;
            iss_tag_d   = req_tag;
            // Bit 3 selects word-sized variants, which do not exist on RV32.
            iss_bits_d  = {req_insn[30], req_insn[29], req_insn[27], req_insn[26],
                           req_insn[14], req_insn[13],
                           (XLEN == 32) ? 1'b0 : req_insn[3]};
        end else if (iss_fire) begin
            iss_valid_d = 1'b0;
        end
    end

    always_comb begin
        tag_mem_d = tag_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        if (iss_fire) begin
            tag_mem_d[wr_ptr_q] = iss_tag_q;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({iss_fire, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_rd_d    = wb_rd_q;
        wb_tag_d   = wb_tag_q;
        err_d      = err_q;
        if (res_fire) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = unit_dout_rd;
            // A result with no tag outstanding is still delivered, tagged 0, and flagged.
            wb_tag_d   = pop ? tag_mem_q[rd_ptr_q] : '0;
            err_d      = err_q || !pop;
        end else if (wb_valid_q && wb_ready) begin
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            iss_valid_q <= 1'b0;
            iss_rs1_q   <= '0;
            iss_rs2_q   <= '0;
            iss_rs3_q   <= '0;
            iss_tag_q   <= '0;
            iss_bits_q  <= '0;
            tag_mem_q   <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_tag_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_rs1_q   <= iss_rs1_d;
            iss_rs2_q   <= iss_rs2_d;
            iss_rs3_q   <= iss_rs3_d;
            iss_tag_q   <= iss_tag_d;
            iss_bits_q  <= iss_bits_d;
            tag_mem_q   <= tag_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_tag_q    <= wb_tag_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_rvb_shifter_issue.sv
// Directed bench for rvb_shifter_issue: decode vectors, credit limit, backpressure,
// ordering, spurious results and mid-stream reset; a 64-bit instance checks insn3.
module tb_rvb_shifter_issue;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, req_valid, unit_din_ready, unit_dout_valid, wb_ready;
    logic [31:0] req_insn, req_rs1, req_rs2, req_rs3, unit_dout_rd;
    logic [4:0]  req_tag;
    logic        req_ready, unit_din_valid, unit_dout_ready, wb_valid, busy, err;
    logic [31:0] unit_din_rs1, unit_din_rs2, unit_din_rs3, wb_rd;
    logic [4:0]  wb_tag;
    logic        i3, i13, i14, i26, i27, i29, i30;

    logic        w_req_ready, w_din_valid, w_dout_ready, w_wb_valid, w_busy, w_err;
    logic [63:0] w_rs1, w_rs2, w_rs3, w_wb_rd;
    logic [4:0]  w_wb_tag;
    logic        w3, w13, w14, w26, w27, w29, w30;

    rvb_shifter_issue #(.XLEN(32), .DEPTH(4), .TAGW(5)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_insn(req_insn),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3), .req_tag(req_tag),
        .unit_din_valid(unit_din_valid), .unit_din_ready(unit_din_ready),
        .unit_din_rs1(unit_din_rs1), .unit_din_rs2(unit_din_rs2), .unit_din_rs3(unit_din_rs3),
        .unit_din_insn3(i3), .unit_din_insn13(i13), .unit_din_insn14(i14),
        .unit_din_insn26(i26), .unit_din_insn27(i27), .unit_din_insn29(i29),
        .unit_din_insn30(i30),
        .unit_dout_valid(unit_dout_valid), .unit_dout_ready(unit_dout_ready),
        .unit_dout_rd(unit_dout_rd),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_tag(wb_tag),
        .busy(busy), .err(err)
    );

    rvb_shifter_issue #(.XLEN(64), .DEPTH(4), .TAGW(5)) dut64 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(w_req_ready), .req_insn(req_insn),
        .req_rs1({32'd0, req_rs1}), .req_rs2({32'd0, req_rs2}), .req_rs3({32'd0, req_rs3}),
        .req_tag(req_tag),
        .unit_din_valid(w_din_valid), .unit_din_ready(unit_din_ready),
        .unit_din_rs1(w_rs1), .unit_din_rs2(w_rs2), .unit_din_rs3(w_rs3),
        .unit_din_insn3(w3), .unit_din_insn13(w13), .unit_din_insn14(w14),
        .unit_din_insn26(w26), .unit_din_insn27(w27), .unit_din_insn29(w29),
        .unit_din_insn30(w30),
        .unit_dout_valid(unit_dout_valid), .unit_dout_ready(w_dout_ready),
        .unit_dout_rd({32'd0, unit_dout_rd}),
        .wb_valid(w_wb_valid), .wb_ready(wb_ready), .wb_rd(w_wb_rd), .wb_tag(w_wb_tag),
        .busy(w_busy), .err(w_err)
    );

    typedef struct {
        logic [31:0] insn, rs1, rs2, rs3, rd;
        logic [4:0]  tag;
        logic [6:0]  bits;      // {30,29,27,26,14,13,3} on the 32-bit instance
        logic        insn3_64;
    } vec_t;

    vec_t vecs [5];
    int n_cmp = 0, n_err = 0;
    int accepted = 0, din_fires = 0, res_fires = 0;
    bit auto_tag = 0;
    logic [31:0] din_log [$];
    logic [4:0]  wb_log  [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // Samples handshakes just before the edge, then advances one clock.
    task automatic step();
        bit acc;
        #1;
        acc = req_valid && req_ready;
        if (acc) accepted++;
        if (unit_din_valid && unit_din_ready) begin
            din_fires++;
            din_log.push_back(unit_din_rs1);
        end
        if (unit_dout_valid && unit_dout_ready) res_fires++;
        if (wb_valid && wb_ready) wb_log.push_back(wb_tag);
        @(posedge clock);
        #1;
        if (auto_tag && acc) begin
            if (req_tag == 5'd7) req_valid = 1'b0;
            else begin
                req_tag = req_tag + 5'd1;
                req_rs1 = {27'd0, req_tag};
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h40005033, 32'h80000000, 32'd4, 32'd0, 32'hF8000000, 5'd7, 7'b1000100, 1'b0};
        vecs[1] = '{32'h0000000B, 32'h11111111, 32'h22222222, 32'h33333333, 32'h0000ABCD, 5'd1, 7'b0000000, 1'b1};
        vecs[2] = '{32'hFFFFFFFF, 32'hDEADBEEF, 32'h0000001F, 32'hCAFEF00D, 32'h12345678, 5'd31, 7'b1111110, 1'b1};
        vecs[3] = '{32'h6C006000, 32'h00000001, 32'h00000002, 32'h00000003, 32'h87654321, 5'd16, 7'b1111110, 1'b0};
        vecs[4] = '{32'h20002000, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFF0000, 32'h00FF00FF, 5'd10, 7'b0100010, 1'b0};

        reset = 1'b1; req_valid = 0; req_insn = 0; req_rs1 = 0; req_rs2 = 0; req_rs3 = 0;
        req_tag = 0; unit_din_ready = 0; unit_dout_valid = 0; unit_dout_rd = 0; wb_ready = 0;
        @(posedge clock); #1;
        step();
        chk("rst_din_valid", unit_din_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_wb_rd", wb_rd, 0);
        reset = 1'b0;
        step();

        // Decode vectors: issue, hold, fire, reply two cycles later, write back.
        for (int v = 0; v < 5; v++) begin
            req_valid = 1; req_insn = vecs[v].insn; req_rs1 = vecs[v].rs1;
            req_rs2 = vecs[v].rs2; req_rs3 = vecs[v].rs3; req_tag = vecs[v].tag;
            step();
            req_valid = 0;
            settle();
            chk($sformatf("v%0d_din_valid", v), unit_din_valid, 1);
            chk($sformatf("v%0d_req_ready_held", v), req_ready, 0);
            chk($sformatf("v%0d_bits", v), {i30, i29, i27, i26, i14, i13, i3}, vecs[v].bits);
            chk($sformatf("v%0d_rs1", v), unit_din_rs1, vecs[v].rs1);
            chk($sformatf("v%0d_rs2", v), unit_din_rs2, vecs[v].rs2);
            chk($sformatf("v%0d_rs3", v), unit_din_rs3, vecs[v].rs3);
            chk($sformatf("v%0d_insn3_64", v), w3, vecs[v].insn3_64);
            unit_din_ready = 1;
            step();
            unit_din_ready = 0;
            step();
            unit_dout_valid = 1; unit_dout_rd = vecs[v].rd;
            step();
            unit_dout_valid = 0;
            settle();
            chk($sformatf("v%0d_wb_valid", v), wb_valid, 1);
            chk($sformatf("v%0d_wb_rd", v), wb_rd, vecs[v].rd);
            chk($sformatf("v%0d_wb_tag", v), wb_tag, vecs[v].tag);
            chk($sformatf("v%0d_busy_wb", v), busy, 1);
            wb_ready = 1;
            step();
            wb_ready = 0;
            settle();
            chk($sformatf("v%0d_wb_clear", v), wb_valid, 0);
            chk($sformatf("v%0d_busy_idle", v), busy, 0);
        end

        // Credit limit: 8 back-to-back requests, unit silent.
        din_log.delete(); wb_log.delete();
        accepted = 0; din_fires = 0; res_fires = 0;
        auto_tag = 1; req_insn = 32'h40005033; req_rs2 = 0; req_rs3 = 0;
        req_valid = 1; req_tag = 0; req_rs1 = 0; unit_din_ready = 1;
        for (int c = 0; c < 10; c++) step();
        settle();
        chk("credit_din_fires", din_fires, 4);
        chk("credit_accepted", accepted, 5);
        chk("credit_din_valid", unit_din_valid, 0);
        chk("credit_req_ready", req_ready, 0);

        // One result frees a credit; the held request issues the next cycle.
        unit_dout_valid = 1; unit_dout_rd = 32'hA0; wb_ready = 1;
        settle();
        chk("credit_blocked_same_cycle", unit_din_valid, 0);
        step();
        unit_dout_valid = 0;
        settle();
        chk("ret0_wb_tag", wb_tag, 0);
        chk("ret0_wb_rd", wb_rd, 32'hA0);
        chk("ret0_din_valid", unit_din_valid, 1);
        chk("ret0_din_rs1", unit_din_rs1, 4);

        // Push and pop together at count DEPTH-1: one more credit must remain.
        unit_dout_valid = 1; unit_dout_rd = 32'hA1;
        step();
        unit_dout_valid = 0;
        settle();
        chk("pp_wb_tag", wb_tag, 1);
        chk("pp_din_valid", unit_din_valid, 1);
        chk("pp_din_rs1", unit_din_rs1, 5);
        step();
        settle();
        chk("pp_full_din_valid", unit_din_valid, 0);
        chk("pp_wb_drained", wb_valid, 0);

        // Writeback backpressure.
        wb_ready = 0; unit_dout_valid = 1; unit_dout_rd = 32'hA2;
        step();
        for (int k = 0; k < 10; k++) begin
            unit_dout_rd = 32'hB0 + k;
            settle();
            chk($sformatf("bp%0d_dout_ready", k), unit_dout_ready, 0);
            chk($sformatf("bp%0d_wb_tag", k), wb_tag, 2);
            chk($sformatf("bp%0d_wb_rd", k), wb_rd, 32'hA2);
            step();
        end
        wb_ready = 1;
        for (int k = 0; k < 40 && wb_log.size() < 8; k++) begin
            unit_dout_valid = (res_fires < 8);
            unit_dout_rd = 32'hC0 + res_fires;
            step();
        end
        unit_dout_valid = 0;
        settle();
        chk("order_wb_count", wb_log.size(), 8);
        chk("order_din_count", din_log.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < wb_log.size()) chk($sformatf("order_wb_tag%0d", k), wb_log[k], k);
            if (k < din_log.size()) chk($sformatf("order_din_rs1_%0d", k), din_log[k], k);
        end
        chk("drain_busy", busy, 0);
        chk("drain_err", err, 0);

        // Spurious result with an empty FIFO.
        auto_tag = 0; wb_ready = 0;
        unit_dout_valid = 1; unit_dout_rd = 32'h1234;
        step();
        unit_dout_valid = 0;
        settle();
        chk("spur_wb_valid", wb_valid, 1);
        chk("spur_wb_rd", wb_rd, 32'h1234);
        chk("spur_wb_tag", wb_tag, 0);
        chk("spur_err", err, 1);
        wb_ready = 1;
        step(); step();
        settle();
        chk("spur_err_sticky", err, 1);
        chk("spur_busy", busy, 0);

        // Reset with three tags in flight and a pending writeback.
        wb_ready = 0; unit_din_ready = 1;
        for (int t = 0; t < 4; t++) begin
            req_valid = 1; req_tag = 5'd20 + 5'(t); req_rs1 = 32'd20 + t;
            step();
        end
        req_valid = 0;
        step();
        unit_dout_valid = 1; unit_dout_rd = 32'h55;
        step();
        unit_dout_valid = 0;
        settle();
        chk("pre_rst_wb_valid", wb_valid, 1);
        chk("pre_rst_busy", busy, 1);
        reset = 1;
        step();
        reset = 0;
        settle();
        chk("mid_rst_din_valid", unit_din_valid, 0);
        chk("mid_rst_wb_valid", wb_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_req_ready", req_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
